// File: rtl/sq_wave_period_meter.sv
// rtl/sq_wave_period_meter.sv - measures ON/OFF tick counts of each complete square-wave period
module sq_wave_period_meter #(
    parameter int CLK_PER_TICK = 10,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sq_in,
    output logic [CNT_W-1:0] on_ticks,
    output logic [CNT_W-1:0] off_ticks,
    output logic             overflow,
    output logic             meas_valid,
    output logic             busy
);

    localparam int               PC_W    = $clog2(CLK_PER_TICK + 1);
    localparam logic [PC_W-1:0]  PC_MAX  = PC_W'(CLK_PER_TICK);
    localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SYNC      = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic s1_q, s2_q, s3_q;
    logic rise, fall, any_edge, tick;

    logic [PC_W-1:0]  pc_q, pc_d, pc_cur;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d, lo_cnt_q, lo_cnt_d;
    logic [CNT_W-1:0] on_q, on_d, off_q, off_d;
    logic             ovf_q, ovf_d, ovf_out_q, ovf_out_d, valid_q, valid_d;

    logic busy_w, cnt_hi, cnt_lo, clr_hi, clr_lo, clr_ovf, load;
    logic hi_sat, lo_sat;

    assign rise     = s2_q & ~s3_q;
    assign fall     = ~s2_q & s3_q;
    assign any_edge = rise | fall;

    // pc_q numbers the current cycle inside the tick window; an edge cycle is
    // always cycle 1 of a new window, so a phase of L cycles yields L/CLK_PER_TICK ticks
    assign pc_cur = any_edge ? PC_ONE : pc_q;
    assign tick   = ~any_edge && (pc_q == PC_MAX);
    assign pc_d   = (pc_cur == PC_MAX) ? PC_ONE : pc_cur + 1'b1;

    // State register, synchronizer, tick window and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            pc_q      <= '0;
            hi_cnt_q  <= '0;
            lo_cnt_q  <= '0;
            ovf_q     <= 1'b0;
            on_q      <= '0;
            off_q     <= '0;
            ovf_out_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_q      <= sq_in;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            pc_q      <= pc_d;
            hi_cnt_q  <= hi_cnt_d;
            lo_cnt_q  <= lo_cnt_d;
            ovf_q     <= ovf_d;
            on_q      <= on_d;
            off_q     <= off_d;
            ovf_out_q <= ovf_out_d;
            valid_q   <= valid_d;
        end
    end

    // Next state: enable drop wins from any state, otherwise follow the synchronized edges
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = SYNC;
            SYNC:      if (rise) state_d = MEAS_HIGH;
            MEAS_HIGH: if (fall) state_d = MEAS_LOW;
            MEAS_LOW:  if (rise) state_d = MEAS_HIGH;
            default:   state_d = IDLE;
        endcase
        if (!en) begin
            state_d = IDLE;
        end
    end

    // Per-state control strobes for the tick counters and the result registers
    always_comb begin
        busy_w  = 1'b0;
        cnt_hi  = 1'b0;
        cnt_lo  = 1'b0;
        clr_hi  = 1'b0;
        clr_lo  = 1'b0;
        clr_ovf = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                clr_hi  = 1'b1;
                clr_lo  = 1'b1;
                clr_ovf = 1'b1;
            end
            SYNC: begin
                if (en && rise) begin
                    clr_hi  = 1'b1;
                    clr_ovf = 1'b1;
                end
            end
            MEAS_HIGH: begin
                busy_w = 1'b1;
                if (en) begin
                    if (fall) clr_lo = 1'b1;
                    else      cnt_hi = 1'b1;
                end
            end
            MEAS_LOW: begin
                busy_w = 1'b1;
                if (en) begin
                    if (rise) begin
                        load    = 1'b1;
                        clr_hi  = 1'b1;
                        clr_lo  = 1'b1;
                        clr_ovf = 1'b1;
                    end else begin
                        cnt_lo = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign hi_sat = (hi_cnt_q == CNT_MAX);
    assign lo_sat = (lo_cnt_q == CNT_MAX);

    // Saturating tick counters; a tick that finds a counter full marks the period as overflowed
    always_comb begin
        hi_cnt_d = hi_cnt_q;
        lo_cnt_d = lo_cnt_q;
        ovf_d    = ovf_q;
        if (clr_hi) begin
            hi_cnt_d = '0;
        end else if (cnt_hi && tick) begin
            if (hi_sat) ovf_d    = 1'b1;
            else        hi_cnt_d = hi_cnt_q + 1'b1;
        end
        if (clr_lo) begin
            lo_cnt_d = '0;
        end else if (cnt_lo && tick) begin
            if (lo_sat) ovf_d    = 1'b1;
            else        lo_cnt_d = lo_cnt_q + 1'b1;
        end
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Results are captured only at the rise that closes a full period
    always_comb begin
        on_d      = on_q;
        off_d     = off_q;
        ovf_out_d = ovf_out_q;
        valid_d   = load;
        if (load) begin
            on_d      = hi_cnt_q;
            off_d     = lo_cnt_q;
            ovf_out_d = ovf_q;
        end
    end

    assign on_ticks   = on_q;
    assign off_ticks  = off_q;
    assign overflow   = ovf_out_q;
    assign meas_valid = valid_q;
    assign busy       = busy_w;

endmodule

// File: tb/tb_sq_wave_period_meter.sv
// tb/tb_sq_wave_period_meter.sv - randomized and directed bench with run-length reference model
module tb_sq_wave_period_meter;

    localparam int CPT = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, en, sq_in;
    logic [7:0] on8, off8;
    logic       ovf8, v8, b8;
    logic [3:0] on4, off4;
    logic       ovf4, v4, b4;

    sq_wave_period_meter #(.CLK_PER_TICK(CPT), .CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .en(en), .sq_in(sq_in),
        .on_ticks(on8), .off_ticks(off8), .overflow(ovf8),
        .meas_valid(v8), .busy(b8)
    );

    sq_wave_period_meter #(.CLK_PER_TICK(CPT), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .en(en), .sq_in(sq_in),
        .on_ticks(on4), .off_ticks(off4), .overflow(ovf4),
        .meas_valid(v4), .busy(b4)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state: mode 0 idle, 1 waiting for a rise, 2 measuring
    int         mode;
    int         m;
    int         t_rise, t_fall;
    logic [2:0] hist;
    int         e_on8, e_off8, e_on4, e_off4;
    logic       e_ovf8, e_ovf4, e_valid;
    int         n_valid;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d (edge %0d)", tag, obs, exp, m);
        end
    endtask

    task automatic model_reset();
        mode    = 0;
        hist    = 3'b000;
        e_on8   = 0; e_off8 = 0; e_ovf8 = 1'b0;
        e_on4   = 0; e_off4 = 0; e_ovf4 = 1'b0;
        e_valid = 1'b0;
    endtask

    // One clock edge of the model: the FSM reacts to the input level sampled
    // two and three edges earlier; a period is high length + low length in cycles
    task automatic model_edge();
        logic r, f;
        int lh, ll;
        r = hist[1] & ~hist[2];
        f = ~hist[1] & hist[2];
        hist = {hist[1:0], sq_in};
        e_valid = 1'b0;
        if (!en) begin
            mode = 0;
        end else begin
            case (mode)
                0: mode = 1;
                1: if (r) begin mode = 2; t_rise = m; end
                default: begin
                    if (f) begin
                        t_fall = m;
                    end else if (r) begin
                        lh = (t_fall - t_rise) / CPT;
                        ll = (m - t_fall) / CPT;
                        e_on8  = sat(lh, 255); e_off8 = sat(ll, 255);
                        e_ovf8 = (lh > 255) || (ll > 255);
                        e_on4  = sat(lh, 15);  e_off4 = sat(ll, 15);
                        e_ovf4 = (lh > 15) || (ll > 15);
                        e_valid = 1'b1;
                        n_valid++;
                        t_rise = m;
                    end
                end
            endcase
        end
        m++;
    endtask

    task automatic check_all();
        chk("valid8", v8, e_valid);
        chk("busy8", b8, mode == 2);
        chk("on8", on8, e_on8);
        chk("off8", off8, e_off8);
        chk("ovf8", ovf8, e_ovf8);
        chk("valid4", v4, e_valid);
        chk("busy4", b4, mode == 2);
        chk("on4", on4, e_on4);
        chk("off4", off4, e_off4);
        chk("ovf4", ovf4, e_ovf4);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic phase(input logic level, input int len);
        sq_in = level;
        repeat (len) cyc();
    endtask

    task automatic period(input int h, input int l);
        phase(1'b1, h);
        phase(1'b0, l);
    endtask

    initial begin
        int v0;
        reset = 1'b0;
        en    = 1'b0;
        sq_in = 1'b0;
        m     = 0;
        n_valid = 0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check_all();
        end
        reset = 1'b1;

        // steady 10/30 wave: one result every 40 cycles
        en = 1'b1;
        phase(1'b0, 5);
        repeat (5) period(10, 30);
        chk("p1030_on", on8, 1);
        chk("p1030_off", off8, 3);
        chk("p1030_ovf", ovf8, 0);

        // enable while input already high: the partial high phase is discarded
        en = 1'b0;
        sq_in = 1'b1;
        repeat (5) cyc();
        v0 = n_valid;
        en = 1'b1;
        phase(1'b1, 17);
        phase(1'b0, 37);
        chk("partial_no_valid", n_valid, v0);
        repeat (3) period(25, 37);
        phase(1'b1, 5);
        chk("nonmult_on", on8, 2);
        chk("nonmult_off", off8, 3);

        // saturation on the narrow instance, then a clean period
        phase(1'b0, 20);
        period(200, 20);
        phase(1'b1, 10);
        chk("sat_on4", on4, 15);
        chk("sat_off4", off4, 2);
        chk("sat_ovf4", ovf4, 1);
        chk("sat_on8", on8, 20);
        phase(1'b0, 30);
        phase(1'b1, 4);
        chk("after_sat_ovf4", ovf4, 0);
        chk("after_sat_on4", on4, 1);

        // enable drop during the low phase
        phase(1'b1, 16);
        phase(1'b0, 10);
        en = 1'b0;
        v0 = n_valid;
        phase(1'b0, 15);
        phase(1'b1, 20);
        phase(1'b0, 15);
        chk("en_drop_busy", b8, 0);
        chk("en_drop_no_valid", n_valid, v0);
        en = 1'b1;
        period(30, 30);
        period(20, 40);
        phase(1'b1, 5);

        // random periods with occasional short enable drops
        repeat (40) begin
            period($urandom_range(1, 70), $urandom_range(1, 70));
            if ($urandom_range(0, 5) == 0) begin
                en = 1'b0;
                repeat ($urandom_range(1, 8)) cyc();
                en = 1'b1;
            end
        end
        phase(1'b1, 3);
        period(100, 170);

        // asynchronous reset in the middle of a high phase
        phase(1'b1, 12);
        chk("pre_reset_busy", b8, 1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("async_on8", on8, 0);
        chk("async_off8", off8, 0);
        chk("async_ovf4", ovf4, 0);
        chk("async_valid8", v8, 0);
        chk("async_busy8", b8, 0);
        repeat (3) begin
            @(negedge clk);
            check_all();
        end
        reset = 1'b1;
        v0 = n_valid;
        period(30, 30);
        chk("post_reset_no_valid", n_valid, v0);
        period(15, 45);
        phase(1'b1, 5);
        chk("post_reset_on", on8, 1);
        chk("post_reset_off", off8, 4);
        phase(1'b0, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
